// File: rtl/vga_plot_writer.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_writer
// Description : Pixel sink for the x/y/color/plot drawer stream. On-screen
//               pixels are buffered in a FIFO with their linear frame-buffer
//               address (y*320+x) and written to video memory through a
//               valid/ready port. Off-screen and overflowing pixels are
//               dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_plot_writer #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic        clk,
    input  logic        reset_n,     // active-high synchronous reset
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  color,
    input  logic        plot,
    output logic        plot_ready,
    output logic [16:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic        wr_en,
    input  logic        mem_ready,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int         c_aw       = $clog2(DEPTH);
    localparam logic [9:0] c_screen_w = 10'(SCREEN_W);
    localparam logic [9:0] c_screen_h = 10'(SCREEN_H);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // FIFO storage: {address, colour}
    logic [19:0]     fifo_mem_q [DEPTH];

    logic [c_aw:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]   rd_ptr_q, rd_ptr_d;
    state_t          state_q, state_d;
    logic [16:0]     wr_addr_q, wr_addr_d;
    logic [2:0]      wr_data_q, wr_data_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_count_q, drop_count_d;

    logic            w_full;
    logic            w_empty;
    logic            w_onscreen;
    logic            w_push;
    logic            w_pop;
    logic [16:0]     w_addr;
    logic [19:0]     w_head;

    // Full compares pointer MSBs against the lower bits; evaluated on
    // registered pointers so a same-edge pop never frees a slot early.
    assign w_full     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                        (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_onscreen = ({1'b0, x} < c_screen_w) && ({2'b00, y} < c_screen_h);
    assign w_push     = plot && w_onscreen && !w_full;

    // y*320 + x as y*256 + y*64 + x, full 17-bit width
    assign w_addr     = 17'({y, 8'b0}) + 17'({y, 6'b0}) + 17'(x);
    assign w_head     = fifo_mem_q[rd_ptr_q[c_aw-1:0]];

    // Output stage sequencing, pop decision and drop accounting
    always_comb begin
        state_d      = state_q;
        w_pop        = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_pop) begin
            wr_addr_d = w_head[19:3];
            wr_data_d = w_head[2:0];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (plot && w_full) begin
            overflow_d = 1'b1;
        end

        if (plot && (!w_onscreen || w_full) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (w_push && !reset_n) begin
            fifo_mem_q[wr_ptr_q[c_aw-1:0]] <= {w_addr, color};
        end
    end

    assign plot_ready = !w_full;
    assign wr_en      = (state_q == S_WRITE);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = !w_empty || (state_q == S_WRITE);
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_plot_writer
// Description : Directed self-checking bench for vga_plot_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_plot_writer;

    logic        clk;
    logic        reset_n;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        plot_ready;
    logic [16:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_en;
    logic        mem_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    // Accepted writes as {addr, data}
    logic [19:0] cap [$];

    vga_plot_writer #(.DEPTH(16), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .plot_ready (plot_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write the memory accepts
    always @(posedge clk) begin
        if (!reset_n && wr_en && mem_ready) begin
            cap.push_back({wr_addr, wr_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        plot      = 1'b0;
        x         = '0;
        y         = '0;
        color     = '0;
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        step();
        step();
        reset_n   = 1'b0;
        cap.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (cap.size() !== n) begin
            failures++;
            $display("FAIL %s: writes=%0d required=%0d", name, cap.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wr_en, busy, plot_ready, overflow} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_flags: wr_en/busy/ready/ovf=%b required=0010",
                     {wr_en, busy, plot_ready, overflow});
        end
        checks++;
        if (wr_addr !== 17'd0 || wr_data !== 3'd0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs: addr=%0d data=%0d drops=%0d required=0/0/0",
                     wr_addr, wr_data, drop_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        mem_ready = 1'b1;
        x = 9'd5; y = 8'd2; color = 3'b100; plot = 1'b1;
        step();                       // cycle c+1
        plot = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL single_c1: wr_en=%b required=0", wr_en);
        end
        step();                       // cycle c+2
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 17'd645 || wr_data !== 3'd4) begin
            failures++;
            $display("FAIL single_c2: wr_en=%b addr=%0d data=%0d required=1/645/4",
                     wr_en, wr_addr, wr_data);
        end
        step();
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_after: wr_en=%b busy=%b required=0/0", wr_en, busy);
        end
        repeat (3) step();
        wait_writes(1, 2, "single_count");
    endtask

    task automatic test_stream();
        int ready_low = 0;
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!plot_ready) ready_low++;
            x = 9'(i); y = 8'd239; color = 3'(i); plot = 1'b1;
            step();
        end
        plot = 1'b0;
        wait_writes(20, 10, "stream_count");
        checks++;
        if (ready_low !== 0) begin
            failures++;
            $display("FAIL stream_ready: low_cycles=%0d required=0", ready_low);
        end
        for (int i = 0; i < 20 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== {17'(76480 + i), 3'(i)}) begin
                failures++;
                $display("FAIL stream_order[%0d]: got=%h required=%h", i, cap[i],
                         {17'(76480 + i), 3'(i)});
            end
        end
        checks++;
        if (drop_count !== 8'd0) begin
            failures++;
            $display("FAIL stream_drops: drops=%0d required=0", drop_count);
        end
    endtask

    task automatic test_fill(input int n);
        int exp_drop = (n > 17) ? n - 17 : 0;
        do_reset();
        for (int i = 0; i < n; i++) begin
            x = 9'(i); y = 8'd1; color = 3'(i); plot = 1'b1;
            step();
        end
        plot = 1'b0;
        step();
        checks++;
        if (plot_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 17'd320 || wr_data !== 3'd0) begin
            failures++;
            $display("FAIL fill%0d_hold: ready=%b wr_en=%b addr=%0d data=%0d required=0/1/320/0",
                     n, plot_ready, wr_en, wr_addr, wr_data);
        end
        checks++;
        if (overflow !== (exp_drop != 0) || drop_count !== 8'(exp_drop)) begin
            failures++;
            $display("FAIL fill%0d_drops: ovf=%b drops=%0d required=%b/%0d",
                     n, overflow, drop_count, exp_drop != 0, exp_drop);
        end
        checks++;
        if (cap.size() !== 0) begin
            failures++;
            $display("FAIL fill%0d_stall: writes=%0d required=0", n, cap.size());
        end
        mem_ready = 1'b1;
        wait_writes(17, 40, $sformatf("fill%0d_count", n));
        for (int i = 0; i < 17 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== {17'(320 + i), 3'(i)}) begin
                failures++;
                $display("FAIL fill%0d_order[%0d]: got=%h required=%h", n, i, cap[i],
                         {17'(320 + i), 3'(i)});
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || cap.size() !== 17) begin
            failures++;
            $display("FAIL fill%0d_drain: busy=%b writes=%0d required=0/17", n, busy, cap.size());
        end
    endtask

    task automatic test_offscreen();
        do_reset();
        mem_ready = 1'b1;
        x = 9'd320; y = 8'd0; plot = 1'b1;
        step();
        x = 9'd10; y = 8'd240;
        step();
        plot = 1'b0;
        repeat (4) step();
        checks++;
        if (drop_count !== 8'd2 || cap.size() !== 0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL offscreen: drops=%0d writes=%0d ovf=%b required=2/0/0",
                     drop_count, cap.size(), overflow);
        end
        x = 9'd400; y = 8'd5; plot = 1'b1;
        repeat (300) step();
        plot = 1'b0;
        step();
        checks++;
        if (drop_count !== 8'd255 || cap.size() !== 0) begin
            failures++;
            $display("FAIL offscreen_sat: drops=%0d writes=%0d required=255/0",
                     drop_count, cap.size());
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            x = 9'(i); y = 8'd7; color = 3'b111; plot = 1'b1;
            step();
        end
        plot = 1'b0;
        step();
        checks++;
        if (wr_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: wr_en=%b busy=%b required=1/1", wr_en, busy);
        end
        reset_n = 1'b1;
        step();
        reset_n = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || plot_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_post: wr_en=%b busy=%b ready=%b required=0/0/1",
                     wr_en, busy, plot_ready);
        end
        mem_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (cap.size() !== 0) begin
            failures++;
            $display("FAIL abort_stale: writes=%0d required=0", cap.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_fill(17);
        test_fill(18);
        test_offscreen();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
